// File: rtl/cpu_pkg.sv
// Shared CPU constants: address source encodings and register reset defaults.
// Imported by the address unit and the control unit so both agree on encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    SEL_PC         = 3'd0,
    SEL_ZERO       = 3'd1,
    SEL_ABS        = 3'd2,
    SEL_IND_ZERO_0 = 3'd3,
    SEL_IND_ZERO_1 = 3'd4,
    SEL_IND_ABS_0  = 3'd5,
    SEL_IND_ABS_1  = 3'd6
  } addr_sel_e;

  localparam logic [15:0] RESET_PC_DEFAULT     = 16'h0000;
  localparam logic [7:0]  RESET_OPCODE_DEFAULT = 8'hEA;

endpackage

// File: rtl/address_unit_if.sv
// Control-unit <-> address-unit strobe and address bus; no handshake, one strobe-set per clock.
// master = control unit side, slave = address unit side.
interface address_unit_if;

  logic [7:0]  data_in;
  logic [7:0]  alu_result;
  logic        instruction_load;
  logic        increment_pc;
  logic        indirl_load;
  logic        indirh_load;
  logic        dirl_load;
  logic        dirh_load;
  logic        branch_load;
  logic [2:0]  address_select;
  logic [15:0] address;
  logic [7:0]  opcode_reg;
  logic [15:0] pc;

  modport master (
    output data_in, alu_result, instruction_load, increment_pc,
           indirl_load, indirh_load, dirl_load, dirh_load,
           branch_load, address_select,
    input  address, opcode_reg, pc
  );

  modport slave (
    input  data_in, alu_result, instruction_load, increment_pc,
           indirl_load, indirh_load, dirl_load, dirh_load,
           branch_load, address_select,
    output address, opcode_reg, pc
  );

endinterface

// File: rtl/address_unit_program_counter.sv
// 16-bit program counter: branch (PC + sign-extended offset) beats increment beats hold.
// Latency: new PC visible one cycle after the strobe; no backpressure.
module program_counter
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        increment_pc,
  input  logic        branch_load,
  input  logic [7:0]  offset,
  output logic [15:0] pc
);

  logic [15:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (branch_load)
      pc_next = pc + {{8{offset[7]}}, offset};
    else if (increment_pc)
      pc_next = pc + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/address_unit.sv
// CPU address stage: PC, instruction register, operand latches, branch offset and address mux.
// Latency: address is combinational from registers; loads visible next cycle; no backpressure.
module address_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter logic [7:0]  RESET_OPCODE = RESET_OPCODE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  address_unit_if.slave bus
);

  logic [7:0]  opcode_q;
  logic [7:0]  dirl;
  logic [7:0]  dirh;
  logic [7:0]  indirl;
  logic [7:0]  indirh;
  logic [7:0]  offset;
  logic [15:0] pc;
  logic [15:0] address;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk          (clk),
    .rst          (rst),
    .increment_pc (bus.increment_pc),
    .branch_load  (bus.branch_load),
    .offset       (offset),
    .pc           (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q <= RESET_OPCODE;
      dirl     <= 8'h00;
      dirh     <= 8'h00;
      indirl   <= 8'h00;
      indirh   <= 8'h00;
      offset   <= 8'h00;
    end else begin
      if (bus.instruction_load) opcode_q <= bus.data_in;
      if (bus.dirl_load)        dirl     <= bus.alu_result;
      if (bus.dirh_load)        dirh     <= bus.alu_result;
      if (bus.indirl_load)      indirl   <= bus.alu_result;
      if (bus.indirh_load)      indirh   <= bus.alu_result;
      // Operand-fetch cycles: the last byte fetched before a branch is its offset.
      if (bus.increment_pc && !bus.instruction_load)
        offset <= bus.data_in;
    end
  end

  always_comb begin
    address = pc;
    case (bus.address_select)
      SEL_PC:         address = pc;
      SEL_ZERO:       address = {8'h00, dirl};
      SEL_ABS:        address = {dirh, dirl};
      SEL_IND_ZERO_0: address = {8'h00, indirl};
      SEL_IND_ZERO_1: address = {8'h00, indirl + 8'd1};
      SEL_IND_ABS_0:  address = {indirh, indirl};
      SEL_IND_ABS_1:  address = {indirh, indirl} + 16'd1;
      default:        address = pc;
    endcase
  end

  assign bus.address    = address;
  assign bus.opcode_reg = opcode_q;
  assign bus.pc         = pc;

endmodule

// File: tb/tb_address_unit.sv
// Directed bench for address_unit: reset, fetch, operand latches, address modes, branches, wraps.
module tb_address_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] pc_exp;

  address_unit_if bus ();

  address_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    bus.instruction_load = 1'b0;
    bus.increment_pc     = 1'b0;
    bus.indirl_load      = 1'b0;
    bus.indirh_load      = 1'b0;
    bus.dirl_load        = 1'b0;
    bus.dirh_load        = 1'b0;
    bus.branch_load      = 1'b0;
  endtask

  // One clock with the currently driven strobes, then sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  // Steer the PC to a target with operand-fetch + branch pairs, tracking the expected PC.
  task automatic goto_pc(input logic [15:0] target);
    int n;
    int rem;
    int off;
    logic [15:0] d;
    logic [7:0]  ob;
    n = 0;
    while (pc_exp != target && n < 600) begin
      d   = target - pc_exp;
      rem = int'($signed(d));
      if (rem == 1) begin
        bus.increment_pc = 1'b1;
        tick();
        pc_exp = pc_exp + 16'd1;
      end else begin
        off = rem - 1;
        if (off > 127)  off = 127;
        if (off < -128) off = -128;
        ob = off[7:0];
        bus.data_in      = ob;
        bus.increment_pc = 1'b1;
        tick();
        pc_exp = pc_exp + 16'd1;
        bus.branch_load = 1'b1;
        tick();
        pc_exp = pc_exp + {{8{ob[7]}}, ob};
      end
      n++;
    end
    chk("goto_pc", bus.pc, target);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pc_exp = 16'h0000;
    rst = 1'b0;
    bus.data_in        = 8'h00;
    bus.alu_result     = 8'h00;
    bus.address_select = 3'd0;
    clear_strobes();

    // Reset state
    #12;
    chk("reset_pc", bus.pc, 16'h0000);
    chk("reset_opcode", {8'h00, bus.opcode_reg}, 16'h00EA);
    chk("reset_address", bus.address, 16'h0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_pc_hold", bus.pc, 16'h0000);

    // Fetch: opcode latched and PC advanced on the same edge
    bus.data_in = 8'hA5;
    bus.instruction_load = 1'b1;
    bus.increment_pc = 1'b1;
    tick();
    pc_exp = 16'h0001;
    chk("fetch_opcode", {8'h00, bus.opcode_reg}, 16'h00A5);
    chk("fetch_pc", bus.pc, 16'h0001);

    // Zero page: latch not visible until the next cycle
    bus.alu_result = 8'h42;
    bus.dirl_load = 1'b1;
    bus.address_select = 3'd1;
    #1;
    chk("zero_before_edge", bus.address, 16'h0000);
    tick();
    chk("zero_page", bus.address, 16'h0042);

    // Absolute
    bus.alu_result = 8'h34;
    bus.dirl_load = 1'b1;
    tick();
    bus.alu_result = 8'h12;
    bus.dirh_load = 1'b1;
    tick();
    bus.address_select = 3'd2;
    #1;
    chk("absolute", bus.address, 16'h1234);

    // Simultaneous loads of two latches
    bus.alu_result = 8'h77;
    bus.indirl_load = 1'b1;
    bus.indirh_load = 1'b1;
    tick();
    bus.address_select = 3'd5;
    #1;
    chk("dual_latch", bus.address, 16'h7777);

    // Indirect modes with wrap
    bus.alu_result = 8'hFF;
    bus.indirl_load = 1'b1;
    tick();
    bus.alu_result = 8'h12;
    bus.indirh_load = 1'b1;
    tick();
    bus.address_select = 3'd3;
    #1;
    chk("ind_zero_0", bus.address, 16'h00FF);
    bus.address_select = 3'd4;
    #1;
    chk("ind_zero_1_wrap", bus.address, 16'h0000);
    bus.address_select = 3'd6;
    #1;
    chk("ind_abs_1_carry", bus.address, 16'h1300);
    bus.address_select = 3'd5;
    #1;
    chk("ind_abs_0", bus.address, 16'h12FF);
    chk("abs_unchanged_pc", bus.pc, 16'h0001);
    bus.address_select = 3'd0;

    // Backward branch
    goto_pc(16'h0210);
    bus.data_in = 8'hFE;
    bus.increment_pc = 1'b1;
    tick();
    chk("branch_operand_pc", bus.pc, 16'h0211);
    bus.branch_load = 1'b1;
    tick();
    chk("branch_back", bus.pc, 16'h020F);
    pc_exp = 16'h020F;

    // Forward branch wrapping past FFFF
    goto_pc(16'hFFEF);
    bus.data_in = 8'h7F;
    bus.increment_pc = 1'b1;
    tick();
    chk("branch_wrap_pre", bus.pc, 16'hFFF0);
    bus.branch_load = 1'b1;
    tick();
    chk("branch_wrap", bus.pc, 16'h006F);
    pc_exp = 16'h006F;

    // Branch and increment together: branch wins, old offset used
    bus.data_in = 8'h10;
    bus.increment_pc = 1'b1;
    tick();
    chk("offset_fetch_pc", bus.pc, 16'h0070);
    bus.data_in = 8'h33;
    bus.branch_load = 1'b1;
    bus.increment_pc = 1'b1;
    tick();
    chk("branch_over_inc", bus.pc, 16'h0080);
    pc_exp = 16'h0080;

    // PC wrap and select 7
    goto_pc(16'hFFFF);
    bus.address_select = 3'd7;
    #1;
    chk("sel7_is_pc", bus.address, 16'hFFFF);
    bus.increment_pc = 1'b1;
    tick();
    pc_exp = 16'h0000;
    chk("pc_wrap", bus.pc, 16'h0000);
    chk("sel7_after_wrap", bus.address, 16'h0000);

    // Asynchronous reset mid-run
    bus.address_select = 3'd0;
    goto_pc(16'h1234);
    bus.data_in = 8'h5A;
    bus.instruction_load = 1'b1;
    bus.increment_pc = 1'b1;
    tick();
    pc_exp = 16'h1235;
    chk("pre_reset_opcode", {8'h00, bus.opcode_reg}, 16'h005A);
    rst = 1'b0;
    #1;
    chk("async_reset_pc", bus.pc, 16'h0000);
    chk("async_reset_address", bus.address, 16'h0000);
    chk("async_reset_opcode", {8'h00, bus.opcode_reg}, 16'h00EA);
    bus.address_select = 3'd2;
    #1;
    chk("async_reset_dir", bus.address, 16'h0000);
    bus.address_select = 3'd6;
    #1;
    chk("async_reset_indir", bus.address, 16'h0001);
    rst = 1'b1;
    pc_exp = 16'h0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
